// File: rtl/seq_neuron.sv
// seq_neuron: time-multiplexed N-input neuron with one shared MAC, saturating accumulator and selectable activation
module seq_neuron #(
    parameter int N_INPUTS  = 2,
    parameter int X_WIDTH   = 8,
    parameter int W_WIDTH   = 8,
    parameter int ACC_WIDTH = 16,
    parameter int OUT_WIDTH = 8,
    parameter int SIG_SHIFT = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_INPUTS*X_WIDTH-1:0]   x,
    input  logic [N_INPUTS*W_WIDTH-1:0]   w,
    input  logic [ACC_WIDTH-1:0]          bias,
    input  logic [1:0]                    act_sel,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_WIDTH-1:0]          y,
    output logic                          sat_flag
);
    localparam int PW = X_WIDTH + W_WIDTH;
    localparam int IW = N_INPUTS > 1 ? $clog2(N_INPUTS) : 1;
    localparam logic [IW-1:0] LAST = IW'(N_INPUTS - 1);
    localparam logic [ACC_WIDTH:0] HALF = (ACC_WIDTH + 1)'(1) << (OUT_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MAC, ACT, DONE} state_t;

    state_t                       state, state_next;
    logic [N_INPUTS*X_WIDTH-1:0]  x_r;
    logic [N_INPUTS*W_WIDTH-1:0]  w_r;
    logic [1:0]                   sel_r;
    logic [ACC_WIDTH-1:0]         acc;
    logic [IW-1:0]                idx;
    logic                         sat_int;
    logic                         accept;
    logic signed [X_WIDTH-1:0]    xs;
    logic signed [W_WIDTH-1:0]    ws;
    logic signed [PW-1:0]         prod;
    logic [ACC_WIDTH:0]           sum;
    logic                         ovf;
    logic [ACC_WIDTH-1:0]         acc_next;
    logic                         pos;
    logic                         lin_fits;
    logic [ACC_WIDTH-1:0]         shr;
    logic [ACC_WIDTH:0]           hs;
    logic [OUT_WIDTH-1:0]         y_step, y_relu, y_sig, y_lin, y_act;

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic: one MAC step per input pair, then activation, then wait for downstream
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? MAC : IDLE;
            MAC:     state_next = idx == LAST ? ACT : MAC;
            ACT:     state_next = DONE;
            DONE:    state_next = out_ready ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs; reset blocks acceptance in the same cycle
    always_comb begin
        in_ready = state == IDLE && !rst;
        accept   = in_valid && in_ready;
    end

    // Shared MAC: full-width product sign-extended one bit past the accumulator, clamped on overflow
    always_comb begin
        xs       = x_r[int'(idx)*X_WIDTH +: X_WIDTH];
        ws       = w_r[int'(idx)*W_WIDTH +: W_WIDTH];
        prod     = xs * ws;
        sum      = {acc[ACC_WIDTH-1], acc} + {{(ACC_WIDTH+1-PW){prod[PW-1]}}, prod};
        ovf      = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
        acc_next = ovf ? {sum[ACC_WIDTH], {(ACC_WIDTH-1){~sum[ACC_WIDTH]}}} : sum[ACC_WIDTH-1:0];
    end

    // Activation functions evaluated on the final accumulator
    always_comb begin
        pos      = !acc[ACC_WIDTH-1] && |acc;
        y_step   = OUT_WIDTH'(pos);
        y_relu   = !pos ? '0 : (|acc[ACC_WIDTH-1:OUT_WIDTH] ? '1 : acc[OUT_WIDTH-1:0]);
        shr      = $signed(acc) >>> SIG_SHIFT;
        hs       = {shr[ACC_WIDTH-1], shr} + HALF;
        y_sig    = hs[ACC_WIDTH] ? '0 : (|hs[ACC_WIDTH-1:OUT_WIDTH] ? '1 : hs[OUT_WIDTH-1:0]);
        lin_fits = &acc[ACC_WIDTH-1:OUT_WIDTH-1] || ~|acc[ACC_WIDTH-1:OUT_WIDTH-1];
        y_lin    = lin_fits ? acc[OUT_WIDTH-1:0] : {acc[ACC_WIDTH-1], {(OUT_WIDTH-1){~acc[ACC_WIDTH-1]}}};
        y_act    = sel_r == 2'd0 ? y_step :
                   sel_r == 2'd1 ? y_relu :
                   sel_r == 2'd2 ? y_sig  : y_lin;
    end

    // Datapath: capture operands on accept, accumulate, publish result, retire on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            idx       <= '0;
            sat_int   <= 1'b0;
            out_valid <= 1'b0;
            y         <= '0;
            sat_flag  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    x_r     <= x;
                    w_r     <= w;
                    sel_r   <= act_sel;
                    acc     <= bias;
                    idx     <= '0;
                    sat_int <= 1'b0;
                end
                MAC: begin
                    acc <= acc_next;
                    idx <= idx + 1'b1;
                    if (ovf)
                        sat_int <= 1'b1;
                end
                ACT: begin
                    y         <= y_act;
                    sat_flag  <= sat_int;
                    out_valid <= 1'b1;
                end
                DONE: if (out_ready)
                    out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_neuron.sv
// tb_seq_neuron: scoreboard bench for seq_neuron with an arithmetic reference model
module tb_seq_neuron;
    localparam int N  = 4;
    localparam int XW = 8;
    localparam int WW = 8;
    localparam int AW = 16;
    localparam int OW = 8;
    localparam int SS = 2;
    localparam longint AMAX = (longint'(1) << (AW - 1)) - 1;
    localparam longint AMIN = -(longint'(1) << (AW - 1));
    localparam longint YMAX = (longint'(1) << OW) - 1;
    localparam longint LMAX = (longint'(1) << (OW - 1)) - 1;
    localparam longint LMIN = -(longint'(1) << (OW - 1));

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N*XW-1:0] x = '0;
    logic [N*WW-1:0] w = '0;
    logic [AW-1:0] bias = '0;
    logic [1:0]    act_sel = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [OW-1:0] y;
    logic          sat_flag;

    int xa[N];
    int wa[N];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_acc = 0;
    int rcount = 0;
    bit rand_bp = 0;
    int qy[$];
    int qs[$];
    int qt[$];

    seq_neuron #(
        .N_INPUTS(N), .X_WIDTH(XW), .W_WIDTH(WW),
        .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SIG_SHIFT(SS)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .w(w), .bias(bias), .act_sel(act_sel),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: accumulate with per-step clamp, then apply the chosen activation
    function automatic void model(input int b, input int sel, output int ey, output int es);
        longint a;
        longint v;
        a  = b;
        es = 0;
        for (int i = 0; i < N; i++) begin
            a += longint'(xa[i]) * longint'(wa[i]);
            if (a > AMAX) begin a = AMAX; es = 1; end
            else if (a < AMIN) begin a = AMIN; es = 1; end
        end
        case (sel)
            0: v = a > 0 ? 1 : 0;
            1: v = a <= 0 ? 0 : (a > YMAX ? YMAX : a);
            2: begin
                v = (a >>> SS) + (LMAX + 1);
                v = v < 0 ? 0 : (v > YMAX ? YMAX : v);
            end
            default: begin
                v = a < LMIN ? LMIN : (a > LMAX ? LMAX : a);
                v = v & YMAX;
            end
        endcase
        ey = int'(v);
    endfunction

    task automatic scramble();
        x       = (N*XW)'($urandom);
        w       = (N*WW)'($urandom);
        bias    = AW'($urandom);
        act_sel = 2'($urandom);
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            xa[i] = int'($urandom_range(0, 255)) - 128;
            wa[i] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    // Wait for in_ready, present the bundle, record the expectation at the accept edge
    task automatic send(input int b, input int sel, input bit keep, input bit expect_out, input bit chk_gap);
        int n;
        int ey;
        int es;
        n = 0;
        forever begin
            @(negedge clk);
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            if (in_ready) break;
            in_valid = keep;
            scramble();
            n++;
            if (n > 200) begin
                chk("accept_timeout", 0, 1);
                return;
            end
        end
        for (int i = 0; i < N; i++) begin
            x[i*XW +: XW] = XW'(xa[i]);
            w[i*WW +: WW] = WW'(wa[i]);
        end
        bias     = AW'(b);
        act_sel  = 2'(sel);
        in_valid = 1'b1;
        model(b, sel, ey, es);
        @(posedge clk);
        #1;
        if (chk_gap) chk("accept_gap", cyc - last_acc, N + 3);
        last_acc = cyc;
        if (expect_out) begin
            qy.push_back(ey);
            qs.push_back(es);
            qt.push_back(cyc);
        end
        in_valid = keep;
        scramble();
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((qy.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", qy.size(), 0);
    endtask

    // Monitor: each new result is popped from the scoreboard and checked
    initial begin
        bit prev;
        int ey;
        int es;
        int t;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid && !prev) begin
                rcount++;
                if (qy.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    ey = qy.pop_front();
                    es = qs.pop_front();
                    t  = qt.pop_front();
                    chk("y", int'(y), ey);
                    chk("sat_flag", int'(sat_flag), es);
                    chk("latency", cyc - t, N + 1);
                end
            end
            prev = out_valid;
        end
    end

    initial begin
        int r0;
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_y", int'(y), 0);
        chk("reset_sat", int'(sat_flag), 0);
        chk("reset_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", int'(in_ready), 1);

        // AND gate truth table
        for (int k = 0; k < 4; k++) begin
            xa = '{k >> 1, k & 1, 0, 0};
            wa = '{20, 20, 0, 0};
            send(-30, 0, 0, 1, 0);
        end
        drain();

        // Backpressure: result must hold while out_ready is low
        out_ready = 1'b0;
        xa = '{1, 1, 0, 0};
        wa = '{20, 20, 0, 0};
        send(-30, 0, 0, 1, 0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_seen", int'(out_valid), 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", int'(out_valid), 1);
            chk("bp_hold_y", int'(y), 1);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_in_ready", int'(in_ready), 1);

        // Saturation then a clean evaluation
        xa = '{127, 127, 127, 127};
        wa = '{127, 127, 127, 127};
        send(0, 1, 0, 1, 0);
        xa = '{1, 1, 1, 1};
        wa = '{1, 1, 1, 1};
        send(0, 1, 0, 1, 0);
        drain();

        // Hard-sigmoid and linear corner values driven through the bias
        wa = '{0, 0, 0, 0};
        rand_ops();
        wa = '{0, 0, 0, 0};
        send(0, 2, 0, 1, 0);
        send(40, 2, 0, 1, 0);
        send(-32768, 2, 0, 1, 0);
        send(-10, 3, 0, 1, 0);
        drain();

        // Reset at the second MAC edge discards the transaction
        rand_ops();
        send(1000, 3, 0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mac_reset_in_ready", int'(in_ready), 1);
        chk("mac_reset_out_valid", int'(out_valid), 0);
        chk("mac_reset_y", int'(y), 0);
        chk("mac_reset_sat", int'(sat_flag), 0);
        repeat (N + 3) @(posedge clk);
        rand_ops();
        send(-20, 3, 0, 1, 0);
        drain();

        // Back-to-back with in_valid held and operands scrambled mid-flight
        r0 = rcount;
        for (int k = 0; k < 3; k++) begin
            rand_ops();
            send(int'($urandom_range(0, 400)) - 200, k + 1, 1, 1, k > 0);
        end
        in_valid = 1'b0;
        drain();
        chk("b2b_result_count", rcount - r0, 3);

        // Random traffic with random downstream backpressure
        rand_bp = 1;
        for (int k = 0; k < 40; k++) begin
            rand_ops();
            send(k % 2 ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 400)) - 200,
                 int'($urandom_range(0, 3)), 0, 1, 0);
        end
        rand_bp = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/seq_neuron.md
Name: seq_neuron

Overview:
- Parametrised, time-multiplexed single neuron. Generalises the fixed 2-input combinational neuron to N_INPUTS signed inputs.
- Datapath: one shared multiplier-accumulator, bias preload, accumulator saturation, and a run-time selectable activation.
- Valid/ready handshakes on input and output, so neurons can be chained into layers or fed from a weight/feature sequencer.

Parameters:
- N_INPUTS, 2, number of x/w pairs per evaluation (>=1).
- X_WIDTH, 8, signed input width.
- W_WIDTH, 8, signed weight width.
- ACC_WIDTH, 16, signed accumulator and bias width (must be >= X_WIDTH+W_WIDTH).
- OUT_WIDTH, 8, activation output width.
- SIG_SHIFT, 2, arithmetic right shift applied to the accumulator in hard-sigmoid mode.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept a bundle.
- x  in  N_INPUTS*X_WIDTH  packed signed inputs; x[0] in LSBs.
- w  in  N_INPUTS*W_WIDTH  packed signed weights; w[0] in LSBs.
- bias  in  ACC_WIDTH  signed bias.
- act_sel  in  2  activation: 0 step, 1 relu, 2 hard-sigmoid, 3 signed linear.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- y  out  OUT_WIDTH  activation result.
- sat_flag  out  1  accumulator saturated during this evaluation; valid with out_valid.

Behaviour:
- Reset: clk and rst are the only clock/reset. Reset is synchronous and active-high. While rst=1 at a rising edge: state to IDLE, out_valid=0, y=0, sat_flag=0, accumulator=0, index=0.
- in_ready is combinational: (state==IDLE) && !rst.
- FSM states: IDLE, MAC, ACT, DONE.
- IDLE: on the edge where in_valid && in_ready, register x, w and act_sel; load acc<=bias and idx<=0; clear the internal saturation flag; go to MAC.
- MAC: each edge does acc <= sat(acc + x[idx]*w[idx]) and idx<=idx+1. When idx==N_INPUTS-1, go to ACT.
  - The product is a full signed X_WIDTH+W_WIDTH value, sign-extended to ACC_WIDTH+1 bits.
  - The sum is clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Any clamp sets the internal saturation flag, which is sticky until the next accept.
- ACT: compute y from the final acc, set out_valid<=1, copy the flag to sat_flag, go to DONE.
  - step: y=1 if acc>0, else 0.
  - relu: y=0 if acc<=0, else min(acc, 2^OUT_WIDTH-1).
  - hard-sigmoid: y=clamp((acc>>>SIG_SHIFT)+2^(OUT_WIDTH-1), 0, 2^OUT_WIDTH-1).
  - linear: y=acc clamped to the signed OUT_WIDTH range (two's complement).
- DONE: hold y, sat_flag and out_valid stable until out_valid && out_ready at an edge. Then out_valid<=0 and go to IDLE. y and sat_flag keep their last value.
- Latency: out_valid rises at the (N_INPUTS+1)th rising edge after the accepting edge.
- Throughput: with out_ready tied high, the minimum interval between accepts is N_INPUTS+3 cycles.
- Inputs are sampled only at the accept edge. Changes to x, w, bias or act_sel afterwards have no effect on the result in flight.
- Reset mid-operation (MAC/ACT/DONE): the transaction is discarded, no out_valid is produced, and the reset values above apply.
- rst has priority over every handshake in the same cycle.
- The saturation clamp is applied per accumulation step, not only to the final sum.

Test Plan:
- AND gate, N=2, w0=w1=20, bias=-30, act_sel=0: x=(0,0),(0,1),(1,0),(1,1) gives y=0,0,0,1 and sat_flag=0. Each out_valid is 3 edges after its accept.
- Backpressure: after out_valid, hold out_ready=0 for 5 cycles. y/out_valid stay stable and in_ready=0. Raise out_ready: out_valid drops next edge and in_ready returns high.
- Saturation, N=4: x=127, w=127 all, bias=0, act_sel=1. acc saturates to 32767, sat_flag=1, y=255. The next evaluation with x=1, w=1 reports sat_flag=0, y=4.
- Hard-sigmoid, act_sel=2: acc=0 gives y=128; acc=40 gives y=138; acc=-32768 gives y=0. Linear (act_sel=3) with acc=-10 gives y=8'hF6.
- Reset in MAC: assert rst for 1 cycle at the second MAC edge. No out_valid appears, in_ready=1 the cycle after reset. The next transaction gives the correct result.
- Back-to-back: in_valid and out_ready held high with 3 distinct bundles. Exactly 3 results arrive in order, accept spacing is N_INPUTS+3 cycles, and operand changes during MAC are ignored.
